// File: rtl/rv32_lsu_pkg.sv
// Shared LSU opcode encodings, widths and the latched-request record.
// Opcode classification helpers used by both the FSM and the lane steering.
package rv32_lsu_pkg;

   localparam int LSU_OPCODE_WIDTH        = 4;
   localparam int API_DATA_WIDTH          = 32;
   localparam int API_REGISTER_ADDR_WIDTH = 5;

   localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_NONE = 4'd0;
   localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_LB   = 4'd1;
   localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_LH   = 4'd2;
   localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_LW   = 4'd3;
   localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_LBU  = 4'd4;
   localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_LHU  = 4'd5;
   localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_SB   = 4'd6;
   localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_SH   = 4'd7;
   localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_SW   = 4'd8;

   typedef struct packed {
      logic [LSU_OPCODE_WIDTH-1:0]        op;
      logic [API_DATA_WIDTH-1:0]          wdata;
      logic [API_REGISTER_ADDR_WIDTH-1:0] rd;
   } lsu_req_t;

   function automatic logic lsu_is_load(input logic [LSU_OPCODE_WIDTH-1:0] op);
      return (op == LSU_OPCODE_LB)  || (op == LSU_OPCODE_LH)  || (op == LSU_OPCODE_LW) ||
             (op == LSU_OPCODE_LBU) || (op == LSU_OPCODE_LHU);
   endfunction

   function automatic logic lsu_is_store(input logic [LSU_OPCODE_WIDTH-1:0] op);
      return (op == LSU_OPCODE_SB) || (op == LSU_OPCODE_SH) || (op == LSU_OPCODE_SW);
   endfunction

endpackage

// File: rtl/rv32_lsu_align.sv
// Byte-lane steering, load extract/extend and misalign check (API_LSU_MISALIGN_TRAP_EN).
// Latency: purely combinational.
// Backpressure: none; consumers qualify outputs with their own state.
module rv32_lsu_align
   import rv32_lsu_pkg::*;
(
   input  logic [LSU_OPCODE_WIDTH-1:0] op,
   input  logic [1:0]                  addr_lo,
   input  logic [31:0]                 wdata,
   input  logic [31:0]                 rdata,
   output logic                        is_load,
   output logic                        is_store,
   output logic [3:0]                  be,
   output logic [31:0]                 wdata_lane,
   output logic [31:0]                 ld_data,
   output logic                        misalign
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign is_load  = lsu_is_load(op);
   assign is_store = lsu_is_store(op);

   always_comb begin
      be         = 4'b1111;
      wdata_lane = wdata;
      case (op)
         LSU_OPCODE_SB: begin
            be         = 4'b0001 << addr_lo;
            wdata_lane = {4{wdata[7:0]}};
         end
         LSU_OPCODE_SH: begin
            be         = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      case (addr_lo)
         2'd0:    ld_byte = rdata[7:0];
         2'd1:    ld_byte = rdata[15:8];
         2'd2:    ld_byte = rdata[23:16];
         default: ld_byte = rdata[31:24];
      endcase
      ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      ld_data = rdata;
      case (op)
         LSU_OPCODE_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         LSU_OPCODE_LBU: ld_data = {24'd0, ld_byte};
         LSU_OPCODE_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
         LSU_OPCODE_LHU: ld_data = {16'd0, ld_half};
         default: ;
      endcase
   end

`ifdef API_LSU_MISALIGN_TRAP_EN
   always_comb begin
      case (op)
         LSU_OPCODE_LH, LSU_OPCODE_LHU, LSU_OPCODE_SH: misalign = addr_lo[0];
         LSU_OPCODE_LW, LSU_OPCODE_SW:                 misalign = |addr_lo;
         default:                                      misalign = 1'b0;
      endcase
   end
`else
   // Without trapping, half accesses use a[1] and word accesses use lane 0.
   assign misalign = 1'b0;
`endif

endmodule

// File: rtl/rv32_lsu.sv
// RV32 load/store unit, one aligned word transaction in flight (trap option: API_LSU_MISALIGN_TRAP_EN).
// Latency: accept N, mem_req from N+1; ack at N+1 -> wb_valid N+2, ready N+3 (store: ready N+2).
// Backpressure: req_ready_o only in IDLE; mem_req_o held with stable fields until mem_ack_i.
module rv32_lsu
   import rv32_lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = API_DATA_WIDTH
)(
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               req_valid_i,
   output logic                               req_ready_o,
   input  logic [LSU_OPCODE_WIDTH-1:0]        lsu_opcode_i,
   input  logic [ADDR_W-1:0]                  addr_i,
   input  logic [DATA_W-1:0]                  wdata_i,
   input  logic [API_REGISTER_ADDR_WIDTH-1:0] rd_addr_i,
   output logic                               mem_req_o,
   output logic                               mem_we_o,
   output logic [ADDR_W-1:0]                  mem_addr_o,
   output logic [3:0]                         mem_be_o,
   output logic [DATA_W-1:0]                  mem_wdata_o,
   input  logic                               mem_ack_i,
   input  logic [DATA_W-1:0]                  mem_rdata_i,
   output logic                               wb_valid_o,
   output logic [API_REGISTER_ADDR_WIDTH-1:0] wb_rd_addr_o,
   output logic [DATA_W-1:0]                  wb_data_o,
   output logic                               busy_o,
   output logic                               misalign_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUS  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [1:0] ST_TRAP = 2'd3;

   logic [1:0]                  state_q;
   lsu_req_t                    req_q;
   logic [ADDR_W-1:0]           addr_q;
   logic [DATA_W-1:0]           wb_data_q;

   logic                        idle;
   logic                        accept;
   logic [LSU_OPCODE_WIDTH-1:0] sel_op;
   logic [1:0]                  sel_lo;
   logic                        is_load;
   logic                        is_store;
   logic [3:0]                  lane_be;
   logic [31:0]                 lane_wdata;
   logic [31:0]                 ld_data;
   logic                        misalign;

   assign idle   = (state_q == ST_IDLE);
   assign accept = req_valid_i & idle;

   // In IDLE the aligner classifies the incoming op; afterwards it works on the latched one.
   assign sel_op = idle ? lsu_opcode_i : req_q.op;
   assign sel_lo = idle ? addr_i[1:0]  : addr_q[1:0];

   rv32_lsu_align u_align (
      .op         (sel_op),
      .addr_lo    (sel_lo),
      .wdata      (req_q.wdata),
      .rdata      (mem_rdata_i),
      .is_load    (is_load),
      .is_store   (is_store),
      .be         (lane_be),
      .wdata_lane (lane_wdata),
      .ld_data    (ld_data),
      .misalign   (misalign)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         req_q     <= '0;
         addr_q    <= '0;
         wb_data_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  req_q  <= '{op: lsu_opcode_i, wdata: wdata_i, rd: rd_addr_i};
                  addr_q <= addr_i;
                  // NONE (and unknown encodings) are consumed without touching the bus.
                  if (is_load | is_store) begin
                     state_q <= misalign ? ST_TRAP : ST_BUS;
                  end
               end
            end
            ST_BUS: begin
               if (mem_ack_i) begin
                  wb_data_q <= ld_data;
                  state_q   <= is_load ? ST_RESP : ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready_o  = idle;
   assign busy_o       = ~idle;
   assign mem_req_o    = (state_q == ST_BUS);
   assign mem_we_o     = mem_req_o & is_store;
   assign mem_addr_o   = mem_req_o ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign mem_be_o     = mem_req_o ? lane_be : 4'b0000;
   assign mem_wdata_o  = mem_we_o ? lane_wdata : '0;
   assign wb_valid_o   = (state_q == ST_RESP);
   assign wb_rd_addr_o = wb_valid_o ? req_q.rd : '0;
   assign wb_data_o    = wb_valid_o ? wb_data_q : '0;
   assign misalign_o   = (state_q == ST_TRAP);

endmodule

// File: tb/tb_rv32_lsu.sv
// Scoreboard bench for rv32_lsu: directed loads/stores, latency, reset and misalign cases.
module tb_rv32_lsu;
   import rv32_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [3:0]  lsu_opcode_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [4:0]  rd_addr_i;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_addr_o;
   logic [31:0] wb_data_o;
   logic        busy_o;
   logic        misalign_o;

   always #5 clk = ~clk;

   rv32_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .lsu_opcode_i (lsu_opcode_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .rd_addr_i    (rd_addr_i),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_be_o     (mem_be_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_ack_i    (mem_ack_i),
      .mem_rdata_i  (mem_rdata_i),
      .wb_valid_o   (wb_valid_o),
      .wb_rd_addr_o (wb_rd_addr_o),
      .wb_data_o    (wb_data_o),
      .busy_o       (busy_o),
      .misalign_o   (misalign_o)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
      logic [7:0]  len;
   } mem_exp_t;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_exp_t;

   mem_exp_t mem_q[$];
   wb_exp_t  wb_q[$];
   int       mis_exp = 0;
   int       n_checks = 0;
   int       n_fails  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory responder: acks after ack_delay extra cycles, or follows manual drive.
   logic        auto_ack = 1'b1;
   logic        man_ack  = 1'b0;
   logic [31:0] man_rdata = 32'h0;
   logic [31:0] rdata_next = 32'h0;
   int          ack_delay = 0;
   int          ack_cnt   = 0;

   initial begin
      mem_ack_i   = 1'b0;
      mem_rdata_i = 32'hDEAD_0000;
   end

   always @(posedge clk) begin
      #2;
      if (auto_ack) begin
         if (mem_req_o) begin
            mem_ack_i   = (ack_cnt == ack_delay);
            mem_rdata_i = mem_ack_i ? rdata_next : 32'hDEAD_0000;
            ack_cnt++;
         end else begin
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'hDEAD_0000;
            ack_cnt     = 0;
         end
      end else begin
         mem_ack_i   = man_ack;
         mem_rdata_i = man_rdata;
         ack_cnt     = 0;
      end
   end

   // Monitor: pops expectations whenever the DUT presents a bus request or writeback.
   mem_exp_t cur = '0;
   int       req_len = 0;
   int       wb_len  = 0;

   always @(negedge clk) begin
      if (mem_req_o) begin
         if (req_len == 0) begin
            check("mem_req_expected", 32'(mem_q.size() > 0), 32'd1);
            cur = (mem_q.size() > 0) ? mem_q.pop_front() : '0;
         end
         check("mem_addr", mem_addr_o, cur.addr);
         check("mem_be", {28'd0, mem_be_o}, {28'd0, cur.be});
         check("mem_we", {31'd0, mem_we_o}, {31'd0, cur.we});
         if (cur.we) check("mem_wdata", mem_wdata_o, cur.wdata);
         req_len++;
      end else if (req_len > 0) begin
         check("mem_req_len", req_len, {24'd0, cur.len});
         req_len = 0;
      end
      if (wb_valid_o) begin
         if (wb_len == 0) begin
            wb_exp_t w;
            check("wb_expected", 32'(wb_q.size() > 0), 32'd1);
            w = (wb_q.size() > 0) ? wb_q.pop_front() : '0;
            check("wb_rd_addr", {27'd0, wb_rd_addr_o}, {27'd0, w.rd});
            check("wb_data", wb_data_o, w.data);
         end
         wb_len++;
      end else if (wb_len > 0) begin
         check("wb_valid_width", wb_len, 32'd1);
         wb_len = 0;
      end
      if (misalign_o) begin
         check("misalign_expected", 32'(mis_exp > 0), 32'd1);
         if (mis_exp > 0) mis_exp--;
      end
   end

   task automatic exp_mem(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                          input logic we, input logic [7:0] len);
      mem_exp_t e;
      e = '{addr: a, be: be, wdata: wd, we: we, len: len};
      mem_q.push_back(e);
   endtask

   task automatic exp_wb(input logic [4:0] rd, input logic [31:0] d);
      wb_exp_t e;
      e = '{rd: rd, data: d};
      wb_q.push_back(e);
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called 1 time unit after an edge; returns 1 time unit after the accept edge.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] rd);
      int guard = 0;
      while (!req_ready_o && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (!req_ready_o) check("req_ready_timeout", {31'd0, req_ready_o}, 32'd1);
      req_valid_i  = 1'b1;
      lsu_opcode_i = op;
      addr_i       = a;
      wdata_i      = wd;
      rd_addr_i    = rd;
      @(posedge clk);
      #1;
      req_valid_i  = 1'b0;
      lsu_opcode_i = LSU_OPCODE_NONE;
      addr_i       = 32'h0;
      wdata_i      = 32'h0;
      rd_addr_i    = 5'd0;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst          = 1'b1;
      req_valid_i  = 1'b0;
      lsu_opcode_i = LSU_OPCODE_NONE;
      addr_i       = 32'h0;
      wdata_i      = 32'h0;
      rd_addr_i    = 5'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
      check("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
      check("rst_misalign", {31'd0, misalign_o}, 32'd0);
      check("rst_mem_addr", mem_addr_o, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      settle(1);

      // SB to byte 3
      exp_mem(32'h1000, 4'b1000, 32'hA5A5_A5A5, 1'b1, 8'd1);
      issue(LSU_OPCODE_SB, 32'h1003, 32'h0000_00A5, 5'd1);
      settle(3);

      // LB / LBU of byte 1 = 0x80
      rdata_next = 32'h1234_80FF;
      exp_mem(32'h2000, 4'b1111, 32'h0, 1'b0, 8'd1);
      exp_wb(5'd3, 32'hFFFF_FF80);
      issue(LSU_OPCODE_LB, 32'h2001, 32'h0, 5'd3);
      settle(3);
      exp_mem(32'h2000, 4'b1111, 32'h0, 1'b0, 8'd1);
      exp_wb(5'd4, 32'h0000_0080);
      issue(LSU_OPCODE_LBU, 32'h2001, 32'h0, 5'd4);
      settle(3);

      // LH upper half, ack delayed 3 cycles -> request held 4 cycles
      ack_delay  = 3;
      rdata_next = 32'h8001_7FFF;
      exp_mem(32'h2000, 4'b1111, 32'h0, 1'b0, 8'd4);
      exp_wb(5'd6, 32'hFFFF_8001);
      issue(LSU_OPCODE_LH, 32'h2002, 32'h0, 5'd6);
      settle(7);
      ack_delay = 0;

      // LW latency with immediate ack
      rdata_next = 32'hDEAD_BEEF;
      exp_mem(32'h4000, 4'b1111, 32'h0, 1'b0, 8'd1);
      exp_wb(5'd5, 32'hDEAD_BEEF);
      issue(LSU_OPCODE_LW, 32'h4000, 32'h0, 5'd5);
      check("lw_ready_n1", {31'd0, req_ready_o}, 32'd0);
      check("lw_busy_n1", {31'd0, busy_o}, 32'd1);
      settle(1);
      check("lw_wb_valid_n2", {31'd0, wb_valid_o}, 32'd1);
      check("lw_ready_n2", {31'd0, req_ready_o}, 32'd0);
      settle(1);
      check("lw_ready_n3", {31'd0, req_ready_o}, 32'd1);
      check("lw_wb_valid_n3", {31'd0, wb_valid_o}, 32'd0);
      settle(2);

      // SW latency: ready returns at N+2
      exp_mem(32'h6004, 4'b1111, 32'hCAFE_F00D, 1'b1, 8'd1);
      issue(LSU_OPCODE_SW, 32'h6004, 32'hCAFE_F00D, 5'd0);
      check("sw_ready_n1", {31'd0, req_ready_o}, 32'd0);
      settle(1);
      check("sw_ready_n2", {31'd0, req_ready_o}, 32'd1);
      settle(2);

      // SH upper half
      exp_mem(32'h5000, 4'b1100, 32'hABCD_ABCD, 1'b1, 8'd1);
      issue(LSU_OPCODE_SH, 32'h5002, 32'h1234_ABCD, 5'd0);
      settle(3);

      // NONE is consumed without a bus request
      issue(LSU_OPCODE_NONE, 32'h8000, 32'h0, 5'd1);
      check("none_ready", {31'd0, req_ready_o}, 32'd1);
      check("none_mem_req", {31'd0, mem_req_o}, 32'd0);
      settle(3);

      // More extract cases, including rd=0
      rdata_next = 32'h8001_7FFF;
      exp_mem(32'h7000, 4'b1111, 32'h0, 1'b0, 8'd1);
      exp_wb(5'd8, 32'h0000_7FFF);
      issue(LSU_OPCODE_LHU, 32'h7000, 32'h0, 5'd8);
      settle(3);
      rdata_next = 32'h9A00_0000;
      exp_mem(32'h7000, 4'b1111, 32'h0, 1'b0, 8'd1);
      exp_wb(5'd9, 32'hFFFF_FF9A);
      issue(LSU_OPCODE_LB, 32'h7003, 32'h0, 5'd9);
      settle(3);
      rdata_next = 32'h0000_F00F;
      exp_mem(32'h7000, 4'b1111, 32'h0, 1'b0, 8'd1);
      exp_wb(5'd10, 32'hFFFF_F00F);
      issue(LSU_OPCODE_LH, 32'h7000, 32'h0, 5'd10);
      settle(3);
      rdata_next = 32'h0000_0001;
      exp_mem(32'h7004, 4'b1111, 32'h0, 1'b0, 8'd1);
      exp_wb(5'd0, 32'h0000_0001);
      issue(LSU_OPCODE_LW, 32'h7004, 32'h0, 5'd0);
      settle(3);

      // Reset while in BUS, then a late ack
      auto_ack = 1'b0;
      settle(1);
      exp_mem(32'h9000, 4'b1111, 32'h0, 1'b0, 8'd1);
      issue(LSU_OPCODE_LW, 32'h9000, 32'h0, 5'd11);
      check("rstbus_mem_req", {31'd0, mem_req_o}, 32'd1);
      rst = 1'b1;
      settle(1);
      rst       = 1'b0;
      man_ack   = 1'b1;
      man_rdata = 32'h5555_5555;
      check("rstbus_req_dropped", {31'd0, mem_req_o}, 32'd0);
      settle(1);
      man_ack = 1'b0;
      settle(1);
      check("rstbus_ready", {31'd0, req_ready_o}, 32'd1);
      check("rstbus_busy", {31'd0, busy_o}, 32'd0);
      check("rstbus_wb_valid", {31'd0, wb_valid_o}, 32'd0);
      check("rstbus_mem_be", {28'd0, mem_be_o}, 32'd0);
      check("rstbus_mem_addr", mem_addr_o, 32'd0);
      settle(2);
      auto_ack = 1'b1;
      settle(1);

`ifdef API_LSU_MISALIGN_TRAP_EN
      mis_exp = 1;
      issue(LSU_OPCODE_LW, 32'h3002, 32'h0, 5'd7);
      check("mis_lw_pulse", {31'd0, misalign_o}, 32'd1);
      check("mis_lw_mem_req", {31'd0, mem_req_o}, 32'd0);
      settle(1);
      check("mis_lw_pulse_end", {31'd0, misalign_o}, 32'd0);
      check("mis_lw_ready", {31'd0, req_ready_o}, 32'd1);
      settle(2);
      mis_exp = mis_exp + 1;
      issue(LSU_OPCODE_SH, 32'h3001, 32'h0000_1234, 5'd0);
      settle(3);
`else
      rdata_next = 32'h1122_3344;
      exp_mem(32'h3000, 4'b1111, 32'h0, 1'b0, 8'd1);
      exp_wb(5'd7, 32'h1122_3344);
      issue(LSU_OPCODE_LW, 32'h3002, 32'h0, 5'd7);
      check("nomis_lw_flag", {31'd0, misalign_o}, 32'd0);
      settle(3);
      exp_mem(32'h3000, 4'b1111, 32'h0, 1'b0, 8'd1);
      exp_wb(5'd12, 32'h0000_1122);
      issue(LSU_OPCODE_LH, 32'h3003, 32'h0, 5'd12);
      settle(3);
`endif

      settle(3);
      check("mem_q_drained", mem_q.size(), 32'd0);
      check("wb_q_drained", wb_q.size(), 32'd0);
      check("misalign_drained", mis_exp, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
